// File: rtl/wb_pipe_stage.sv
// MEM/WB pipeline stage: single-cycle retire for ALU results, multi-cycle
// handshake with data memory for loads, with a bounded wait and sticky timeout.
module wb_pipe_stage #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [4:0]  ex_mem_write_reg_addr,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_to_reg,
    output logic        dmem_req,
    output logic [9:0]  dmem_addr,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        mem_wb_reg_write,
    output logic [4:0]  mem_wb_write_reg_addr,
    output logic [31:0] mem_wb_write_back_data,
    output logic        mem_timeout_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [REG_W-1:0]    ld_reg_q, ld_reg_d;
    logic                ld_we_q, ld_we_d;
    logic                ld_to_reg_q, ld_to_reg_d;
    logic                req_q, req_d;
    logic                wb_we_q, wb_we_d;
    logic [REG_W-1:0]    wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                err_q, err_d;
    logic                stall_c;

    // Next-state, load bookkeeping and write-back selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_addr_d   = ld_addr_q;
        ld_reg_d    = ld_reg_q;
        ld_we_d     = ld_we_q;
        ld_to_reg_d = ld_to_reg_q;
        req_d       = req_q;
        wb_we_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        err_d       = err_q;
        stall_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_mem_valid && ex_mem_mem_read) begin
                    stall_c     = 1'b1;
                    ld_addr_d   = ex_mem_alu_result[ADDR_W-1:0];
                    ld_reg_d    = ex_mem_write_reg_addr;
                    ld_we_d     = ex_mem_reg_write;
                    ld_to_reg_d = ex_mem_mem_to_reg;
                    cnt_d       = '0;
                    req_d       = 1'b1;
                    state_d     = LOAD_WAIT;
                end else if (ex_mem_valid) begin
                    wb_we_d   = ex_mem_reg_write && (ex_mem_write_reg_addr != REG_W'(0));
                    wb_addr_d = ex_mem_write_reg_addr;
                    wb_data_d = ex_mem_alu_result;
                end
            end
            LOAD_WAIT: begin
                // An ack on the final permitted cycle wins over the timeout
                if (dmem_ack) begin
                    wb_we_d   = ld_we_q && (ld_reg_q != REG_W'(0));
                    wb_addr_d = ld_reg_q;
                    wb_data_d = ld_to_reg_q ? dmem_rdata : DATA_W'(ld_addr_q);
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ld_addr_q   <= '0;
            ld_reg_q    <= '0;
            ld_we_q     <= 1'b0;
            ld_to_reg_q <= 1'b0;
            req_q       <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_addr_q   <= ld_addr_d;
            ld_reg_q    <= ld_reg_d;
            ld_we_q     <= ld_we_d;
            ld_to_reg_q <= ld_to_reg_d;
            req_q       <= req_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    assign mem_stall              = stall_c;
    assign dmem_req               = req_q;
    assign dmem_addr              = ld_addr_q;
    assign mem_wb_reg_write       = wb_we_q;
    assign mem_wb_write_reg_addr  = wb_addr_q;
    assign mem_wb_write_back_data = wb_data_q;
    assign mem_timeout_err        = err_q;

endmodule

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
- REQ-001 SHALL have parameter: MEM_TIMEOUT, default 15, max LOAD_WAIT cycles before a load is abandoned (legal 1..255).
- REQ-002 SHALL use one clock; reset is asynchronous and active-low.
- REQ-003 SHALL have ports:
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous active-low reset.
  - ex_mem_valid  in  1  EX/MEM holds an instruction.
  - ex_mem_alu_result  in  32  ALU result, or load address.
  - ex_mem_write_reg_addr  in  5  destination register.
  - ex_mem_reg_write  in  1  instruction writes the register file.
  - ex_mem_mem_read  in  1  instruction is a load.
  - ex_mem_mem_to_reg  in  1  write-back source: 1 = memory data, 0 = ALU.
  - dmem_req  out  1  load request to data memory.
  - dmem_addr  out  10  load address.
  - dmem_rdata  in  32  memory read data, valid with dmem_ack.
  - dmem_ack  in  1  memory responder completion strobe.
  - mem_stall  out  1  upstream SHALL hold EX/MEM inputs stable while high.
  - mem_wb_reg_write  out  1  register-file write enable to the ID stage.
  - mem_wb_write_reg_addr  out  5  register-file write address.
  - mem_wb_write_back_data  out  32  register-file write data.
  - mem_timeout_err  out  1  sticky load-timeout flag.

Function
- REQ-004 SHALL implement states IDLE and LOAD_WAIT; reset enters IDLE.
- REQ-005 Non-load path: in IDLE with ex_mem_valid=1 and ex_mem_mem_read=0:
  - mem_stall SHALL be 0.
  - On the next edge: mem_wb_reg_write <= ex_mem_reg_write; addr <= ex_mem_write_reg_addr; data <= ex_mem_alu_result.
  - Latency SHALL be 1 cycle.
- REQ-006 Load accept: in IDLE with ex_mem_valid=1 and ex_mem_mem_read=1:
  - mem_stall SHALL be 1 combinationally.
  - On the next edge: latch ex_mem_alu_result[9:0], ex_mem_write_reg_addr, ex_mem_reg_write and ex_mem_mem_to_reg; enter LOAD_WAIT.
- REQ-007 In LOAD_WAIT:
  - dmem_req SHALL be 1 and dmem_addr SHALL equal the latched address, both from registers.
  - EX/MEM inputs SHALL be ignored.
- REQ-008 In LOAD_WAIT with dmem_ack=0: mem_stall SHALL be 1.
- REQ-009 In LOAD_WAIT with dmem_ack=1:
  - mem_stall SHALL be 0 in that cycle.
  - On the edge: return to IDLE and drive the write-back with data = mem_to_reg ? dmem_rdata : latched address zero-extended to 32 bits.
- REQ-010 mem_wb_reg_write SHALL be a single-cycle pulse per retired instruction. It SHALL be 0 whenever no instruction retired in the previous cycle.
- REQ-011 Writes with destination register 0 SHALL be suppressed (mem_wb_reg_write=0). Address and data SHALL still update.
- REQ-012 mem_wb_write_reg_addr and mem_wb_write_back_data SHALL hold their last values when no instruction retires.
- REQ-013 A wait counter SHALL clear on entering LOAD_WAIT and increment each LOAD_WAIT cycle without dmem_ack.
- REQ-014 Timeout: when the counter reaches MEM_TIMEOUT without dmem_ack:
  - mem_stall SHALL be 0 in that cycle.
  - Next edge: enter IDLE, set mem_timeout_err=1, no register write.
- REQ-015 mem_timeout_err SHALL clear only on reset.
- REQ-016 dmem_ack arriving in IDLE SHALL be ignored with no effect on any output.
- REQ-017 dmem_ack in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success; the timeout SHALL NOT fire.
- REQ-018 ex_mem_valid=0 in IDLE SHALL produce no write and mem_stall=0.

Reset
- REQ-019 Asserting reset (low) SHALL immediately force state=IDLE and force every output register to 0: dmem_req, dmem_addr, mem_wb_reg_write, mem_wb_write_reg_addr, mem_wb_write_back_data, mem_timeout_err, wait counter.
- REQ-020 Reset asserted mid-load SHALL abandon the load with no write-back.
- REQ-021 After reset deasserts, the block SHALL operate normally from the first rising edge.

Verification
- REQ-022 ALU op: valid=1, read=0, reg_write=1, addr=5, result=0x0000_1234 -> next cycle mem_wb_reg_write=1, addr=5, data=0x0000_1234, mem_stall=0 throughout.
- REQ-023 Load with 3-cycle latency: valid=1, read=1, to_reg=1, result=0x0000_0040, addr=8; ack on third LOAD_WAIT cycle with rdata=0xDEAD_BEEF ->
  - dmem_req=1 and dmem_addr=0x040 for 3 cycles;
  - mem_stall=1 for 3 cycles then 0;
  - one-cycle write of 0xDEAD_BEEF to register 8.
- REQ-024 ALU op with addr=0, reg_write=1 -> mem_wb_reg_write stays 0; mem_wb_write_back_data updates.
- REQ-025 Load with MEM_TIMEOUT=4 and no ack -> dmem_req high 4 cycles; mem_timeout_err=1 after; no write; a following ALU op still retires normally.
- REQ-026 Reset pulsed low during LOAD_WAIT, then stray dmem_ack=1 in IDLE -> all outputs 0, no write pulse, state IDLE.
